// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and memory-map constants for bus_decoder_ws
// Contents: region_t (decoded target), ws_state_t (wait-state FSM states),
//           region base/limit addresses for the memory space.
package bus_pkg;

   localparam int ADDR_W = 22;

   localparam logic [ADDR_W-1:0] ROM_LIMIT = 22'h007FFF;
   localparam logic [ADDR_W-1:0] RAM_BASE  = 22'h008000;
   localparam logic [ADDR_W-1:0] RAM_LIMIT = 22'h00FFFF;
   localparam logic [ADDR_W-1:0] EXT_BASE  = 22'h010000;
   localparam logic [ADDR_W-1:0] EXT_LIMIT = 22'h1FFFFF;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_ROM,
      REG_RAM,
      REG_EXT,
      REG_IO
   } region_t;

   typedef enum logic [1:0] {
      WS_IDLE,
      WS_WAIT,
      WS_HOLD
   } ws_state_t;

endpackage

// File: rtl/bus_decoder_ws_addr_decode.sv
// rtl/bus_decoder_ws_addr_decode.sv - combinational address/space to region decode
// Ports: address  - CPU address
//        mem_io   - 1 = memory space, 0 = I/O space
//        region   - decoded target, REG_NONE when unmapped
//        io_idx   - I/O device index (address[7:4]), valid when region == REG_IO
module addr_decode
   import bus_pkg::*;
#(
   parameter int IO_DEVS = 8
) (
   input  logic [ADDR_W-1:0] address,
   input  logic              mem_io,
   output region_t           region,
   output logic [3:0]        io_idx
);

   always_comb begin
      region = REG_NONE;
      io_idx = address[7:4];
      if (mem_io) begin
         if (address <= ROM_LIMIT) begin
            region = REG_ROM;
         end else if (address >= RAM_BASE && address <= RAM_LIMIT) begin
            region = REG_RAM;
         end else if (address >= EXT_BASE && address <= EXT_LIMIT) begin
            region = REG_EXT;
         end
      end else begin
         // address[21:8] is deliberately ignored in I/O space
         if ({28'd0, io_idx} < IO_DEVS) begin
            region = REG_IO;
         end
      end
   end

endmodule

// File: rtl/bus_decoder_ws.sv
// rtl/bus_decoder_ws.sv - chip-select decode, wait-state generation and bus error capture
// Ports: clk, arst_n        - clock, asynchronous active-low reset
//        address, mem_io    - CPU address and space select
//        rd_n, wr_n         - CPU strobes, active-low
//        *_cs_n, io_cs_n    - active-low device selects
//        pin_wait           - stall request to CPU
//        bus_err, err_addr  - unmapped/illegal access pulse and captured address
module bus_decoder_ws
   import bus_pkg::*;
#(
   parameter int ROM_WS  = 2,
   parameter int RAM_WS  = 0,
   parameter int EXT_WS  = 1,
   parameter int IO_WS   = 3,
   parameter int IO_DEVS = 8
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic [ADDR_W-1:0]  address,
   input  logic               rd_n,
   input  logic               wr_n,
   input  logic               mem_io,
   output logic               bios_rom_cs_n,
   output logic               bios_ram_cs_n,
   output logic               ext_ram_cs_n,
   output logic [IO_DEVS-1:0] io_cs_n,
   output logic               pin_wait,
   output logic               bus_err,
   output logic [ADDR_W-1:0]  err_addr
);

   if (ROM_WS < 0 || ROM_WS > 15 || RAM_WS < 0 || RAM_WS > 15 ||
       EXT_WS < 0 || EXT_WS > 15 || IO_WS < 0 || IO_WS > 15) begin : g_bad_ws
      $error("bus_decoder_ws: wait-state parameter outside 0..15");
   end
   if (IO_DEVS < 1 || IO_DEVS > 16) begin : g_bad_devs
      $error("bus_decoder_ws: IO_DEVS outside 1..16");
   end

   region_t     region;
   region_t     region_eff;
   logic [3:0]  io_idx;
   logic        strobe;
   logic        illegal;
   logic        access;
   logic [3:0]  ws;

   ws_state_t   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        armed_q, armed_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;

   addr_decode #(.IO_DEVS(IO_DEVS)) u_addr_decode (
      .address (address),
      .mem_io  (mem_io),
      .region  (region),
      .io_idx  (io_idx)
   );

   assign strobe     = (~rd_n) ^ (~wr_n);
   assign illegal    = ~rd_n & ~wr_n;
   assign access     = strobe | illegal;
   assign region_eff = illegal ? REG_NONE : region;

   always_comb begin
      case (region_eff)
         REG_ROM: ws = ROM_WS[3:0];
         REG_RAM: ws = RAM_WS[3:0];
         REG_EXT: ws = EXT_WS[3:0];
         REG_IO:  ws = IO_WS[3:0];
         default: ws = 4'd0;
      endcase
   end

   // Selects follow the decode directly; forced high while reset is held.
   always_comb begin
      bios_rom_cs_n = 1'b1;
      bios_ram_cs_n = 1'b1;
      ext_ram_cs_n  = 1'b1;
      io_cs_n       = '1;
      if (arst_n && strobe) begin
         bios_rom_cs_n = (region_eff != REG_ROM);
         bios_ram_cs_n = (region_eff != REG_RAM);
         ext_ram_cs_n  = (region_eff != REG_EXT);
         for (int i = 0; i < IO_DEVS; i++) begin
            io_cs_n[i] = !(region_eff == REG_IO && io_idx == i[3:0]);
         end
      end
   end

   // armed_q records that both strobes were seen high since the last access,
   // so a strobe held low across reset or HOLD cannot start a new sequence.
   // The IDLE cycle itself is the first wait cycle, so WAIT covers ws-1 cycles:
   // cnt is loaded with ws-1 and WAIT exits when it reaches 1.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      armed_d    = armed_q;
      err_addr_d = err_addr_q;
      pin_wait   = 1'b0;
      bus_err    = 1'b0;
      if (rd_n && wr_n) begin
         armed_d = 1'b1;
      end
      case (state_q)
         WS_IDLE: begin
            if (armed_q && access) begin
               armed_d = 1'b0;
               state_d = WS_HOLD;
               if (region_eff == REG_NONE) begin
                  bus_err    = 1'b1;
                  err_addr_d = address;
               end else if (ws != 4'd0) begin
                  pin_wait = 1'b1;
                  cnt_d    = ws - 4'd1;
                  if (ws != 4'd1) begin
                     state_d = WS_WAIT;
                  end
               end
            end
         end
         WS_WAIT: begin
            if (!strobe) begin
               state_d = WS_IDLE;
            end else begin
               pin_wait = 1'b1;
               if (cnt_q <= 4'd1) begin
                  state_d = WS_HOLD;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         WS_HOLD: begin
            if (rd_n && wr_n) begin
               state_d = WS_IDLE;
            end
         end
         default: state_d = WS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= WS_IDLE;
         cnt_q      <= 4'd0;
         armed_q    <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         armed_q    <= armed_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign err_addr = err_addr_q;

endmodule

// File: tb/tb_bus_decoder_ws.sv
// tb/tb_bus_decoder_ws.sv - directed self-checking bench for bus_decoder_ws
module tb_bus_decoder_ws;

   logic        clk = 1'b0;
   logic        arst_n;
   logic [21:0] address;
   logic        rd_n;
   logic        wr_n;
   logic        mem_io;
   logic        bios_rom_cs_n;
   logic        bios_ram_cs_n;
   logic        ext_ram_cs_n;
   logic [7:0]  io_cs_n;
   logic        pin_wait;
   logic        bus_err;
   logic [21:0] err_addr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bus_decoder_ws dut (
      .clk           (clk),
      .arst_n        (arst_n),
      .address       (address),
      .rd_n          (rd_n),
      .wr_n          (wr_n),
      .mem_io        (mem_io),
      .bios_rom_cs_n (bios_rom_cs_n),
      .bios_ram_cs_n (bios_ram_cs_n),
      .ext_ram_cs_n  (ext_ram_cs_n),
      .io_cs_n       (io_cs_n),
      .pin_wait      (pin_wait),
      .bus_err       (bus_err),
      .err_addr      (err_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later.
   task automatic drive(input logic [21:0] a, input logic mi, input logic r, input logic w);
      @(negedge clk);
      address = a;
      mem_io  = mi;
      rd_n    = r;
      wr_n    = w;
      #1;
   endtask

   task automatic idle();
      drive(22'h0, 1'b1, 1'b1, 1'b1);
   endtask

   initial begin
      arst_n  = 1'b0;
      address = 22'h0;
      rd_n    = 1'b1;
      wr_n    = 1'b1;
      mem_io  = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_pin_wait", {31'd0, pin_wait}, 32'd0);
      chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
      chk("rst_err_addr", {10'd0, err_addr}, 32'd0);
      chk("rst_selects", {21'd0, bios_rom_cs_n, bios_ram_cs_n, ext_ram_cs_n, io_cs_n}, 32'h7FF);
      @(negedge clk);
      arst_n = 1'b1;
      idle();

      // ROM read, 5 cycles: wait high for the first 2 only
      for (int c = 0; c < 5; c++) begin
         drive(22'h000100, 1'b1, 1'b0, 1'b1);
         chk($sformatf("rom_cs_c%0d", c), {31'd0, bios_rom_cs_n}, 32'd0);
         chk($sformatf("rom_wait_c%0d", c), {31'd0, pin_wait}, (c < 2) ? 32'd1 : 32'd0);
         chk($sformatf("rom_err_c%0d", c), {31'd0, bus_err}, 32'd0);
      end
      idle();
      chk("rom_cs_release", {31'd0, bios_rom_cs_n}, 32'd1);

      // BIOS RAM write, zero wait states
      for (int c = 0; c < 3; c++) begin
         drive(22'h008010, 1'b1, 1'b1, 1'b0);
         chk($sformatf("ram_cs_c%0d", c), {31'd0, bios_ram_cs_n}, 32'd0);
         chk($sformatf("ram_rom_cs_c%0d", c), {31'd0, bios_rom_cs_n}, 32'd1);
         chk($sformatf("ram_wait_c%0d", c), {31'd0, pin_wait}, 32'd0);
      end
      idle();

      // I/O read device 3, three wait states
      for (int c = 0; c < 4; c++) begin
         drive(22'h000035, 1'b0, 1'b0, 1'b1);
         chk($sformatf("io_cs_c%0d", c), {24'd0, io_cs_n}, 32'hF7);
         chk($sformatf("io_wait_c%0d", c), {31'd0, pin_wait}, (c < 3) ? 32'd1 : 32'd0);
      end
      idle();

      // I/O device 10 is unmapped
      drive(22'h0000A0, 1'b0, 1'b0, 1'b1);
      chk("io_unmap_cs", {24'd0, io_cs_n}, 32'hFF);
      chk("io_unmap_err", {31'd0, bus_err}, 32'd1);
      chk("io_unmap_wait", {31'd0, pin_wait}, 32'd0);
      drive(22'h0000A0, 1'b0, 1'b0, 1'b1);
      chk("io_unmap_err_pulse", {31'd0, bus_err}, 32'd0);
      chk("io_unmap_err_addr", {10'd0, err_addr}, 32'h0000A0);
      idle();

      // Unmapped memory, then a valid EXT access leaves err_addr alone
      drive(22'h2ABCDE, 1'b1, 1'b0, 1'b1);
      chk("mem_unmap_sel", {21'd0, bios_rom_cs_n, bios_ram_cs_n, ext_ram_cs_n, io_cs_n}, 32'h7FF);
      chk("mem_unmap_err", {31'd0, bus_err}, 32'd1);
      chk("mem_unmap_wait", {31'd0, pin_wait}, 32'd0);
      drive(22'h2ABCDE, 1'b1, 1'b0, 1'b1);
      chk("mem_unmap_err_pulse", {31'd0, bus_err}, 32'd0);
      chk("mem_unmap_err_addr", {10'd0, err_addr}, 32'h2ABCDE);
      idle();
      drive(22'h010000, 1'b1, 1'b0, 1'b1);
      chk("ext_cs", {31'd0, ext_ram_cs_n}, 32'd0);
      chk("ext_wait0", {31'd0, pin_wait}, 32'd1);
      chk("ext_err", {31'd0, bus_err}, 32'd0);
      drive(22'h010000, 1'b1, 1'b0, 1'b1);
      chk("ext_wait1", {31'd0, pin_wait}, 32'd0);
      chk("ext_err_addr_kept", {10'd0, err_addr}, 32'h2ABCDE);
      idle();

      // Both strobes low is illegal
      drive(22'h000000, 1'b1, 1'b0, 1'b0);
      chk("illegal_sel", {21'd0, bios_rom_cs_n, bios_ram_cs_n, ext_ram_cs_n, io_cs_n}, 32'h7FF);
      chk("illegal_err", {31'd0, bus_err}, 32'd1);
      chk("illegal_wait", {31'd0, pin_wait}, 32'd0);
      drive(22'h000000, 1'b1, 1'b0, 1'b0);
      chk("illegal_err_addr", {10'd0, err_addr}, 32'h0);
      idle();

      // ROM read aborted after one wait cycle, then a fresh access
      drive(22'h000100, 1'b1, 1'b0, 1'b1);
      chk("abort_wait0", {31'd0, pin_wait}, 32'd1);
      drive(22'h000100, 1'b1, 1'b1, 1'b1);
      chk("abort_wait_drop", {31'd0, pin_wait}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         drive(22'h000100, 1'b1, 1'b0, 1'b1);
         chk($sformatf("abort_fresh_c%0d", c), {31'd0, pin_wait}, (c < 2) ? 32'd1 : 32'd0);
      end
      idle();

      // Reset mid-WAIT of an I/O access
      drive(22'h2ABCDE, 1'b1, 1'b0, 1'b1);
      idle();
      chk("pre_rst_err_addr", {10'd0, err_addr}, 32'h2ABCDE);
      drive(22'h000035, 1'b0, 1'b0, 1'b1);
      chk("rst_io_wait0", {31'd0, pin_wait}, 32'd1);
      @(negedge clk);
      arst_n = 1'b0;
      #1;
      chk("midrst_wait", {31'd0, pin_wait}, 32'd0);
      chk("midrst_err", {31'd0, bus_err}, 32'd0);
      chk("midrst_io_cs", {24'd0, io_cs_n}, 32'hFF);
      chk("midrst_err_addr", {10'd0, err_addr}, 32'd0);
      @(negedge clk);
      arst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         drive(22'h000035, 1'b0, 1'b0, 1'b1);
         chk($sformatf("postrst_nowait_c%0d", c), {31'd0, pin_wait}, 32'd0);
      end
      drive(22'h000035, 1'b0, 1'b1, 1'b1);
      drive(22'h000035, 1'b0, 1'b0, 1'b1);
      chk("postrst_fresh_wait", {31'd0, pin_wait}, 32'd1);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
